// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(8,4) SECDED definitions
// Purpose: codeword bit map, syndrome/parity helpers and status encoding
// shared by the encoder and decoder.
// Ports: none (package).
package hamming_pkg;

    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D1_IDX = 2;
    localparam int P3_IDX = 3;
    localparam int D2_IDX = 4;
    localparam int D3_IDX = 5;
    localparam int D4_IDX = 6;
    localparam int P4_IDX = 7;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_SINGLE = 2'd1,
        ST_DOUBLE = 2'd2
    } status_e;

    // Syndrome {s3,s2,s1}; a nonzero value is the 1-based position in c[6:0].
    function automatic logic [2:0] calc_syndrome(input logic [7:0] c);
        logic s1, s2, s3;
        s1 = c[P1_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D4_IDX];
        s2 = c[P2_IDX] ^ c[D1_IDX] ^ c[D3_IDX] ^ c[D4_IDX];
        s3 = c[P3_IDX] ^ c[D2_IDX] ^ c[D3_IDX] ^ c[D4_IDX];
        return {s3, s2, s1};
    endfunction

    function automatic logic calc_parity(input logic [7:0] c);
        return (^c[6:0]) ^ c[P4_IDX];
    endfunction

    function automatic status_e classify(input logic [2:0] s, input logic p);
        if (p)
            return ST_SINGLE;
        else if (s != 3'd0)
            return ST_DOUBLE;
        else
            return ST_CLEAN;
    endfunction

    function automatic logic [3:0] extract_data(input logic [7:0] c);
        return {c[D4_IDX], c[D3_IDX], c[D2_IDX], c[D1_IDX]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome and overall parity
// Purpose: computes the 3-bit syndrome and the overall parity of a codeword.
// Ports: code (8-bit codeword in), syn (syndrome {s3,s2,s1} out),
//        par (XOR of all 8 bits out).
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [7:0] code,
    output logic [2:0] syn,
    output logic       par
);

    assign syn = calc_syndrome(code);
    assign par = calc_parity(code);

endmodule

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - two-stage pipelined SECDED Hamming(8,4) decoder
// Purpose: corrects single-bit errors, flags double-bit errors, returns data
// and status on a valid/ready stream and keeps saturating error counters.
// Ports: clk, rstn (async active-low); in_valid/in_ready/data_in (codeword in);
//        out_valid/out_ready/data_out/err_single/err_double/syndrome (result);
//        cnt_clr (sync clear), cnt_single/cnt_double (saturating counts).
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_single,
    output logic             err_double,
    output logic [2:0]       syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    logic       s1_valid;
    logic [7:0] s1_code;
    logic [2:0] s1_syn;
    logic       s1_par;

    logic [2:0] in_syn;
    logic       in_par;

    logic       s2_load;
    logic       s2_take;
    status_e    st;
    logic [7:0] fixed;

    hamming_syndrome u_syndrome (
        .code (data_in),
        .syn  (in_syn),
        .par  (in_par)
    );

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    // A word actually moves into stage 2 only when stage 1 holds one.
    assign s2_take  = s2_load && s1_valid;

    // Correction: parity error with zero syndrome means c7 itself flipped,
    // so data bits stay as received; double errors pass data uncorrected.
    always_comb begin
        st    = classify(s1_syn, s1_par);
        fixed = s1_code;
        if (st == ST_SINGLE && s1_syn != 3'd0)
            fixed[3'(s1_syn - 3'd1)] = ~s1_code[3'(s1_syn - 3'd1)];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= data_in;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            syndrome   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out   <= extract_data(fixed);
                err_single <= (st == ST_SINGLE);
                err_double <= (st == ST_DOUBLE);
                syndrome   <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (s2_take) begin
            if (st == ST_SINGLE && cnt_single != '1)
                cnt_single <= cnt_single + CNT_W'(1);
            if (st == ST_DOUBLE && cnt_double != '1)
                cnt_double <= cnt_double + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// tb/tb_hamming_decoder.sv - self-checking bench for hamming_decoder
module tb_hamming_decoder;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [3:0] d;
        logic       es;
        logic       ed;
        logic [2:0] syn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       data_in = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       data_out;
    logic             err_single;
    logic             err_double;
    logic [2:0]       syndrome;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic bp_mode = 1'b0;
    int   bp_phase = 0;
    logic saw_in_ready_low = 1'b0;
    logic stall_prev = 1'b0;
    exp_t held;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .syndrome   (syndrome),
        .cnt_clr    (cnt_clr),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c    = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Reference by nearest codeword search; syndrome as XOR of set positions.
    function automatic exp_t model(input logic [7:0] c);
        exp_t e;
        logic [7:0] diff;
        e.syn = 3'd0;
        for (int i = 0; i < 7; i++)
            if (c[i]) e.syn = e.syn ^ 3'(i + 1);
        e.d  = {c[6], c[5], c[4], c[2]};
        e.es = 1'b0;
        e.ed = 1'b1;
        for (int d = 0; d < 16; d++) begin
            diff = c ^ enc(4'(d));
            if ($countones(diff) <= 1) begin
                e.d  = 4'(d);
                e.es = ($countones(diff) == 1);
                e.ed = 1'b0;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bp_mode) begin
            out_ready = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
            bp_phase++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({data_out, err_single, err_double, syndrome}), 32'(held));
            end
            if (!in_ready) saw_in_ready_low = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("err_single", 32'(err_single), 32'(e.es));
                    chk("err_double", 32'(err_double), 32'(e.ed));
                    chk("syndrome", 32'(syndrome), 32'(e.syn));
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {data_out, err_single, err_double, syndrome};
        end
    end

    task automatic send_exp(input logic [7:0] c, input exp_t e);
        int n = 0;
        data_in  = c;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        send_exp(c, model(c));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] c;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_flags", 32'({err_single, err_double}), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_cnt_single", 32'(cnt_single), 32'd0);
        chk("rst_cnt_double", 32'(cnt_double), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        send_exp(8'h55, '{d: 4'b1011, es: 1'b0, ed: 1'b0, syn: 3'd0});
        send_exp(8'h00, '{d: 4'h0, es: 1'b0, ed: 1'b0, syn: 3'd0});
        send_exp(8'hFF, '{d: 4'hF, es: 1'b0, ed: 1'b0, syn: 3'd0});
        drain();
        chk("clean_cnt_single", 32'(cnt_single), 32'd0);

        send_exp(8'h45, '{d: 4'b1011, es: 1'b1, ed: 1'b0, syn: 3'b101});
        drain();
        chk("single_cnt", 32'(cnt_single), 32'd1);

        send_exp(8'hD5, '{d: 4'b1011, es: 1'b1, ed: 1'b0, syn: 3'b000});
        drain();
        chk("parity_cnt", 32'(cnt_single), 32'd2);

        send_exp(8'h56, '{d: 4'b1011, es: 1'b0, ed: 1'b1, syn: 3'b011});
        drain();
        chk("double_cnt", 32'(cnt_double), 32'd1);

        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = enc(4'(2 * i + 1));
            case (i % 4)
                1: c = c ^ (8'h01 << i);
                2: c = c ^ (8'h01 << i) ^ (8'h01 << ((i + 3) % 8));
                3: c = c ^ 8'h80;
                default: ;
            endcase
            send(c);
        end
        drain();
        bp_mode = 1'b0;
        chk("bp_in_ready_dropped", 32'(saw_in_ready_low), 32'd1);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_cnt_single", 32'(cnt_single), 32'd0);
        chk("clr_cnt_double", 32'(cnt_double), 32'd0);
        for (int i = 0; i < 5; i++) send(enc(4'(i + 3)) ^ (8'h01 << (i % 7)));
        drain();
        chk("sat_cnt_single", 32'(cnt_single), 32'd3);
        chk("sat_cnt_double", 32'(cnt_double), 32'd0);

        send(enc(4'd9) ^ 8'h10);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        drain();
        chk("clr_coincident", 32'(cnt_single), 32'd0);

        send(enc(4'd3));
        send(enc(4'd4) ^ 8'h01);
        #3;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outputs", 32'({data_out, err_single, err_double, syndrome}), 32'd0);
        chk("mid_rst_counters", 32'({cnt_single, cnt_double}), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        send_exp(8'h55, '{d: 4'b1011, es: 1'b0, ed: 1'b0, syn: 3'd0});
        send_exp(8'h45, '{d: 4'b1011, es: 1'b1, ed: 1'b0, syn: 3'b101});
        drain();
        chk("resume_cnt_single", 32'(cnt_single), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
